// File: rtl/miner_pkg.sv
// ---------------------------------------------------------------------------
// miner_pkg
// Shared definitions for the mining datapath blocks.
//   - cmp_state_e   : hash/target compare FSM state encoding
//   - HASH_W_DEF    : default hash/target width in bits
//   - NONCE_W_DEF   : default nonce width in bits
//   - SLICE_W_DEF   : default compare slice width in bits
//   - SLICE_CNT_DEF : slice count for the default widths
//   - slice_count() : number of slices a hash of a given width splits into
// ---------------------------------------------------------------------------
package miner_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } cmp_state_e;

    localparam int HASH_W_DEF    = 256;
    localparam int NONCE_W_DEF   = 32;
    localparam int SLICE_W_DEF   = 32;
    localparam int SLICE_CNT_DEF = HASH_W_DEF / SLICE_W_DEF;

    function automatic int slice_count(input int hash_w, input int slice_w);
        return hash_w / slice_w;
    endfunction

endpackage

// File: rtl/slice_cmp.sv
// ---------------------------------------------------------------------------
// slice_cmp
// Combinational unsigned magnitude compare of one hash slice against the
// matching target slice.
// Ports:
//   a  : hash slice   (SLICE_W bits, unsigned)
//   b  : target slice (SLICE_W bits, unsigned)
//   lt : a < b
//   gt : a > b
// When neither lt nor gt is set the slices are equal.
// ---------------------------------------------------------------------------
module slice_cmp
    import miner_pkg::*;
#(
    parameter int SLICE_W = SLICE_W_DEF
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    output logic               lt,
    output logic               gt
);

    assign lt = (a < b);
    assign gt = (a > b);

endmodule

// File: rtl/hash_target_cmp.sv
// ---------------------------------------------------------------------------
// hash_target_cmp
// Multi-cycle hash-versus-target checker. Accepts one candidate hash/nonce
// per handshake, compares the hash against the target one SLICE_W slice per
// cycle starting from the most-significant slice, and stops at the first
// unequal slice. A hit is hash < target (strict). The first winning
// hash/nonce is held until found_clr; later hits only raise found_ovf.
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   in_valid     : candidate present
//   in_ready     : block can accept a candidate (IDLE)
//   in_hash      : candidate hash, MSB first
//   in_nonce     : nonce that produced in_hash
//   target       : difficulty target, sampled at accept
//   res_valid    : one-cycle pulse when a comparison finishes
//   res_hit      : qualifies res_valid, 1 when hash < target
//   found        : sticky, a winning candidate is held
//   found_hash   : held winning hash
//   found_nonce  : held winning nonce
//   found_ovf    : sticky, another hit arrived while found was set
//   found_clr    : clears found, found_ovf, found_hash, found_nonce
//   cmp_count    : (HASH_TARGET_CMP_STATS_EN only) completed compares
//   hit_count    : (HASH_TARGET_CMP_STATS_EN only) completed hits
//
// Build option: define HASH_TARGET_CMP_STATS_EN to add the two 32-bit
// wrapping statistics counters and their ports.
// ---------------------------------------------------------------------------
module hash_target_cmp
    import miner_pkg::*;
#(
    parameter int HASH_W  = HASH_W_DEF,
    parameter int SLICE_W = SLICE_W_DEF,
    parameter int NONCE_W = NONCE_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [HASH_W-1:0]  in_hash,
    input  logic [NONCE_W-1:0] in_nonce,
    input  logic [HASH_W-1:0]  target,
    output logic               res_valid,
    output logic               res_hit,
    output logic               found,
    output logic [HASH_W-1:0]  found_hash,
    output logic [NONCE_W-1:0] found_nonce,
    output logic               found_ovf,
    input  logic               found_clr
`ifdef HASH_TARGET_CMP_STATS_EN
    ,
    output logic [31:0]        cmp_count,
    output logic [31:0]        hit_count
`endif
);

    localparam int N   = slice_count(HASH_W, SLICE_W);
    localparam int K_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [K_W-1:0] K_MAX = K_W'(N - 1);

    // The slice walk assumes the hash splits into whole slices.
    if (HASH_W % SLICE_W != 0) begin : g_width_check
        $error("hash_target_cmp: HASH_W must be a multiple of SLICE_W");
    end

    cmp_state_e         state_q, state_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [HASH_W-1:0]  hash_q, hash_d;
    logic [HASH_W-1:0]  target_q, target_d;
    logic [NONCE_W-1:0] nonce_q, nonce_d;
    logic               in_ready_q, in_ready_d;
    logic               res_valid_q, res_valid_d;
    logic               res_hit_q, res_hit_d;
    logic               found_q, found_d;
    logic [HASH_W-1:0]  found_hash_q, found_hash_d;
    logic [NONCE_W-1:0] found_nonce_q, found_nonce_d;
    logic               found_ovf_q, found_ovf_d;
`ifdef HASH_TARGET_CMP_STATS_EN
    logic [31:0]        cmp_count_q, cmp_count_d;
    logic [31:0]        hit_count_q, hit_count_d;
`endif

    logic [SLICE_W-1:0] hash_slice;
    logic [SLICE_W-1:0] target_slice;
    logic               slice_lt;
    logic               slice_gt;
    logic               decide;
    logic               hit;

    // Only one comparator exists; the current slice index steers both
    // operands into it.
    assign hash_slice   = hash_q[int'(k_q) * SLICE_W +: SLICE_W];
    assign target_slice = target_q[int'(k_q) * SLICE_W +: SLICE_W];

    slice_cmp #(
        .SLICE_W (SLICE_W)
    ) u_slice_cmp (
        .a  (hash_slice),
        .b  (target_slice),
        .lt (slice_lt),
        .gt (slice_gt)
    );

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        hash_d        = hash_q;
        target_d      = target_q;
        nonce_d       = nonce_q;
        in_ready_d    = in_ready_q;
        res_valid_d   = 1'b0;
        res_hit_d     = 1'b0;
        found_d       = found_q;
        found_hash_d  = found_hash_q;
        found_nonce_d = found_nonce_q;
        found_ovf_d   = found_ovf_q;
        decide        = 1'b0;
        hit           = 1'b0;

        case (state_q)
            IDLE: begin
                // in_ready_q is low for the first cycle after reset, so the
                // accept has to be gated by the registered ready.
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    hash_d     = in_hash;
                    target_d   = target;
                    nonce_d    = in_nonce;
                    k_d        = K_MAX;
                    state_d    = CMP;
                    in_ready_d = 1'b0;
                end
            end
            CMP: begin
                in_ready_d = 1'b0;
                if (slice_lt) begin
                    decide = 1'b1;
                    hit    = 1'b1;
                end else if (slice_gt) begin
                    decide = 1'b1;
                end else if (k_q == '0) begin
                    // Full equality is a miss: a hit must be strictly below.
                    decide = 1'b1;
                end else begin
                    k_d = k_q - K_W'(1);
                end
                if (decide) begin
                    state_d     = DONE;
                    res_valid_d = 1'b1;
                    res_hit_d   = hit;
                end
            end
            DONE: begin
                state_d    = IDLE;
                in_ready_d = 1'b1;
            end
            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b0;
            end
        endcase

        // A hit captured on the same edge as found_clr takes priority: the
        // new winner loads and the overflow history is discarded.
        if (decide && hit) begin
            if (!found_q || found_clr) begin
                found_d       = 1'b1;
                found_hash_d  = hash_q;
                found_nonce_d = nonce_q;
                found_ovf_d   = 1'b0;
            end else begin
                found_ovf_d = 1'b1;
            end
        end else if (found_clr) begin
            found_d       = 1'b0;
            found_hash_d  = '0;
            found_nonce_d = '0;
            found_ovf_d   = 1'b0;
        end
    end

`ifdef HASH_TARGET_CMP_STATS_EN
    // Counters advance on the edge that raises res_valid and wrap freely.
    always_comb begin
        cmp_count_d = cmp_count_q;
        hit_count_d = hit_count_q;
        if (decide) begin
            cmp_count_d = cmp_count_q + 32'd1;
        end
        if (decide && hit) begin
            hit_count_d = hit_count_q + 32'd1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            k_q           <= '0;
            hash_q        <= '0;
            target_q      <= '0;
            nonce_q       <= '0;
            in_ready_q    <= 1'b0;
            res_valid_q   <= 1'b0;
            res_hit_q     <= 1'b0;
            found_q       <= 1'b0;
            found_hash_q  <= '0;
            found_nonce_q <= '0;
            found_ovf_q   <= 1'b0;
`ifdef HASH_TARGET_CMP_STATS_EN
            cmp_count_q   <= '0;
            hit_count_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            hash_q        <= hash_d;
            target_q      <= target_d;
            nonce_q       <= nonce_d;
            in_ready_q    <= in_ready_d;
            res_valid_q   <= res_valid_d;
            res_hit_q     <= res_hit_d;
            found_q       <= found_d;
            found_hash_q  <= found_hash_d;
            found_nonce_q <= found_nonce_d;
            found_ovf_q   <= found_ovf_d;
`ifdef HASH_TARGET_CMP_STATS_EN
            cmp_count_q   <= cmp_count_d;
            hit_count_q   <= hit_count_d;
`endif
        end
    end

    assign in_ready    = in_ready_q;
    assign res_valid   = res_valid_q;
    assign res_hit     = res_hit_q;
    assign found       = found_q;
    assign found_hash  = found_hash_q;
    assign found_nonce = found_nonce_q;
    assign found_ovf   = found_ovf_q;
`ifdef HASH_TARGET_CMP_STATS_EN
    assign cmp_count   = cmp_count_q;
    assign hit_count   = hit_count_q;
`endif

endmodule

// File: doc/hash_target_cmp.md
# hash_target_cmp

Multi-cycle, parametrised hash-versus-target checker for the mining datapath. It accepts one candidate hash and nonce per handshake from the SHA-256d core and compares the hash against a target, most-significant slice first, terminating early. It reports a per-candidate result and latches the first winning hash and nonce until software clears it. It replaces the single-cycle 256-bit combinational compare with a registered, area-bounded compare.

## Interface
Parameters:
- HASH_W, 256, hash/target width in bits; must be a multiple of SLICE_W.
- SLICE_W, 32, bits compared per cycle.
- NONCE_W, 32, nonce width.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  candidate present.
- in_ready  out  1  block can accept a candidate.
- in_hash  in  HASH_W  candidate hash, unsigned, bit HASH_W-1 is the MSB.
- in_nonce  in  NONCE_W  nonce that produced in_hash.
- target  in  HASH_W  difficulty target, sampled at accept.
- res_valid  out  1  one-cycle pulse: the comparison finished.
- res_hit  out  1  qualifies res_valid: 1 when hash < target.
- found  out  1  sticky: a winning candidate is held.
- found_hash  out  HASH_W  held winning hash.
- found_nonce  out  NONCE_W  held winning nonce.
- found_ovf  out  1  sticky: a further hit occurred while found=1.
- found_clr  in  1  clears found, found_ovf, found_hash and found_nonce.

## Operation
- FSM states are IDLE, CMP and DONE. Reset state is IDLE.
- IDLE: in_ready=1. On in_valid=1, the block registers in_hash, in_nonce and target, sets slice index k=N-1 (N=HASH_W/SLICE_W) and moves to CMP.
- CMP: in_ready=0. The block compares hash slice k against target slice k, both unsigned:
  - hash slice < target slice: decide hit.
  - hash slice > target slice: decide miss.
  - equal with k>0: decrement k and stay in CMP.
  - equal with k=0: decide miss (hash == target is not a hit).
  - A decision moves the FSM to DONE.
- DONE: res_valid=1 and res_hit=decision for exactly one cycle, with in_ready=0. The FSM then returns to IDLE.
- Capture: on entry to DONE with a hit:
  - found=0: load found_hash and found_nonce, set found.
  - found=1: keep the held values unchanged and set found_ovf.
- found_clr is honoured in any state. If found_clr coincides with a hit capture, the capture wins: the new values load, found stays 1, and found_ovf is cleared.
- Reset values: in_ready=0 during reset and 1 from the first cycle after release. res_valid, res_hit, found and found_ovf are 0; found_hash and found_nonce are 0; statistics counters are 0.
- Reset asserted mid-compare drops the in-flight candidate with no res_valid.

## Timing
- Accept edge E0 (in_valid & in_ready). The first slice is examined in the cycle after E0.
- A decision after examining j slices (1 ≤ j ≤ N) gives res_valid in cycle j+1 after E0.
  - Best-case latency: 2 cycles.
  - Worst-case latency: N+1 cycles (9 for the defaults).
- in_ready returns to 1 in the cycle after res_valid. Maximum throughput is one candidate per j+2 cycles.
- found, found_hash, found_nonce and found_ovf update on the same edge that raises res_valid.
- found_clr takes effect on the next edge.
- in_hash, in_nonce and target are don't-care outside the accept cycle.

## Configuration
- HASH_TARGET_CMP_STATS_EN defined:
  - Adds outputs cmp_count (32 bits, increments on every res_valid) and hit_count (32 bits, increments on every res_valid with res_hit).
  - Both counters wrap 0xFFFFFFFF→0 and are cleared only by rst.
- HASH_TARGET_CMP_STATS_EN undefined: the counters and their ports are absent. Other behaviour is identical.

## Structure
- Shared package, miner_pkg, holds:
  - state encoding (IDLE=2'd0, CMP=2'd1, DONE=2'd2);
  - default widths HASH_W_DEF=256 and NONCE_W_DEF=32;
  - slice-count helper constant.
- One sub-module: slice_cmp. It is combinational, SLICE_W-wide, and outputs lt/gt. It is instantiated once; the FSM muxes slice k into it.
- Elaboration-time check that HASH_W % SLICE_W == 0.

## Test plan
- Early hit: target=0x00000000FFFF…F, hash=0x00000000_0000ABCD…, nonce=0x12345678. Expect res_valid at E0+3, res_hit=1, found=1, found_nonce=0x12345678.
- Early miss: hash MSB slice 0x00000001, target MSB slice 0x00000000. Expect res_valid at E0+2, res_hit=0, found unchanged.
- Equality: hash == target == 0x0…0FFFF. Expect 8 slices walked, res_valid at E0+9, res_hit=0.
- Second hit while found=1, nonce 0xAAAA0001 then 0xAAAA0002. Expect found_nonce=0xAAAA0001 and found_ovf=1. Then found_clr coincident with a third hit (nonce 0xAAAA0003): expect found_nonce=0xAAAA0003, found=1, found_ovf=0.
- rst pulse during CMP at k=5. Expect no res_valid, all outputs at reset values, in_ready=1 in the cycle after release. A following candidate compares correctly.
- With HASH_TARGET_CMP_STATS_EN: run 10 candidates, 3 hits. Expect cmp_count=10, hit_count=3. Preload the counter to 0xFFFFFFFF via force and run one more: expect cmp_count wraps to 0.
